// File: rtl/hs_unit_skid_buf_pkg.sv
// Shared constants for the two-entry skid buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hs_unit_skid_buf_pkg;

    // Occupancy is 0..2, so two bits are enough.
    localparam int unsigned HS_SKID_COUNT_W = 2;

endpackage : hs_unit_skid_buf_pkg

// File: rtl/hs_unit_dff_ce_sclr.sv
// Clock-enabled data register with synchronous clear and async active-low reset.
// Latency: 1 cycle from d to q when ce is high.
// Backpressure: none; the caller decides when to load by driving ce.
module hs_unit_dff_ce_sclr #(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     aresetn,
    input  logic     sclr,
    input  logic     ce,
    input  DATA_TYPE d,
    output DATA_TYPE q
);

    // Clear wins over load so a flush never lets a beat slip through.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            q <= RESET_VALUE;
        end else if (sclr) begin
            q <= RESET_VALUE;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule : hs_unit_dff_ce_sclr

// File: rtl/hs_unit_skid_buf.sv
// Two-entry ready/valid register slice; all handshake outputs come from flops.
// Latency: 1 cycle from upstream acceptance to m_valid/m_data.
// Backpressure: s_ready drops one cycle after a stall; the skid entry absorbs the in-flight beat.
module hs_unit_skid_buf
    import hs_unit_skid_buf_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       sclr,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  DATA_TYPE                   s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output DATA_TYPE                   m_data,
    output logic [HS_SKID_COUNT_W-1:0] count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } hs_skid_state_e;

    hs_skid_state_e state, state_nxt;
    logic           load_main;
    logic           load_skid;
    logic           main_from_skid;
    logic           s_acc;
    DATA_TYPE       skid_q;
    DATA_TYPE       main_d;

    // s_ready is low straight out of reset, so nothing is taken before the first edge.
    assign s_acc = s_valid & s_ready;

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // s_ready is registered from the next state to break the backward combinational path.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s_ready <= 1'b0;
        end else if (sclr) begin
            s_ready <= 1'b1;
        end else begin
            s_ready <= (state_nxt != FULL);
        end
    end

    // Next-state and register load enables.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (sclr) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_acc) begin
                        load_main = 1'b1;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (s_acc && m_ready) begin
                        load_main = 1'b1;
                    end else if (s_acc) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (m_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // Upstream is held off here (s_ready is 0), so only the drain matters.
                    if (m_ready) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Main register source: the skid entry on drain, otherwise the upstream payload.
    always_comb begin
        main_d = main_from_skid ? skid_q : s_data;
    end

    // Occupancy and output valid decode directly from the state flops.
    always_comb begin
        m_valid = (state != EMPTY);
        case (state)
            BUSY:    count = HS_SKID_COUNT_W'(1);
            FULL:    count = HS_SKID_COUNT_W'(2);
            default: count = HS_SKID_COUNT_W'(0);
        endcase
    end

    hs_unit_dff_ce_sclr #(
        .DATA_TYPE   (DATA_TYPE),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .clk     (clk),
        .aresetn (aresetn),
        .sclr    (sclr),
        .ce      (load_main),
        .d       (main_d),
        .q       (m_data)
    );

    hs_unit_dff_ce_sclr #(
        .DATA_TYPE   (DATA_TYPE),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .clk     (clk),
        .aresetn (aresetn),
        .sclr    (sclr),
        .ce      (load_skid),
        .d       (s_data),
        .q       (skid_q)
    );

endmodule : hs_unit_skid_buf

// File: doc/hs_unit_skid_buf.md
# hs_unit_skid_buf

Two-entry ready/valid register slice (skid buffer) that decouples a producer from a consumer with a generic payload type. It breaks the combinational path in both directions: `m_valid`/`m_data` and `s_ready` are all flop outputs. It is used wherever a pipeline stage needs backpressure, since a plain clock-enabled register cannot accept data while its output is stalled.

## Interface
- `DATA_TYPE`, default `logic`: payload type, any packed type.
- `RESET_VALUE`, default `'0`: value loaded into both data registers on `aresetn` or `sclr`.

- `clk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `sclr`  in  1  synchronous clear; flushes the buffer.
- `s_valid`  in  1  upstream data valid.
- `s_ready`  out  1  upstream ready (registered).
- `s_data`  in  DATA_TYPE  upstream payload.
- `m_valid`  out  1  downstream data valid (registered).
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_TYPE  downstream payload (registered).
- `count`  out  2  occupancy, 0..2.

## Operation
- Transfer rules:
  - Upstream transfer is `s_valid & s_ready` at a rising edge.
  - Downstream transfer is `m_valid & m_ready` at a rising edge.
- Storage: main register drives `m_data`; skid register holds one overflow beat.
- State machine (`EMPTY`, `BUSY`, `FULL`):
  - EMPTY: `s_valid` → load main, go to BUSY. Otherwise stay.
  - BUSY, `s_valid & m_ready`: load main from `s_data`, stay BUSY.
  - BUSY, `s_valid & !m_ready`: load skid from `s_data`, go to FULL.
  - BUSY, `!s_valid & m_ready`: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, `m_ready`: main ← skid, go to BUSY. `s_ready` is 0, so no upstream beat is taken.
  - FULL, `!m_ready`: hold.
- Outputs:
  - `m_valid` = (state != EMPTY).
  - `count` = 0, 1 or 2 for EMPTY, BUSY or FULL respectively.
  - `s_ready` is a flop: next value = (next_state != FULL).
- `sclr`:
  - Has priority over all handshakes.
  - Next state is EMPTY, both data registers take `RESET_VALUE`, `s_ready` next value is 1.
  - Any beat offered or presented in the `sclr` cycle is discarded, and no transfer is counted.
- `s_data` is ignored when `s_valid` is 0; `m_ready` is ignored in EMPTY.
- Ordering: strict FIFO; no beat is lost or duplicated outside `sclr`/reset.
- Data integrity: `m_data` must not change while `m_valid & !m_ready`.

## Timing
- Reset (`aresetn` low) values:
  - state EMPTY, `m_valid`=0, `count`=0.
  - `s_ready`=0.
  - `m_data` and skid register = `RESET_VALUE`.
- First edge after `aresetn` deasserts sets `s_ready`=1; no upstream beat is accepted before that edge.
- Latency: 1 cycle, i.e. a beat accepted at edge N is visible on `m_data` with `m_valid`=1 after edge N.
- Throughput: 1 beat/cycle sustained when `m_ready` is held high.
- Backpressure: `s_ready` falls one cycle after the consumer stalls (the skid entry absorbs the in-flight beat). `s_ready` rises in the cycle after the FULL→BUSY drain.
- Reset mid-operation: contents are lost immediately (asynchronous), and outputs take the reset values above.

## Structure
- State enum `hs_skid_state_e` (`EMPTY`, `BUSY`, `FULL`) is local to the module and not exported.
- No new shared-package entries are needed. `DATA_TYPE` comes in via the parameter.
- Both data registers are instances of `hs_unit_dff_ce_sclr`:
  - `ce` driven by the load enables from the state machine.
  - `sclr` driven by the block's `sclr`.
- The state register, `s_ready` register and next-state logic live in this module.

## Test plan
- Reset then stream: release reset, drive `s_data`=0x11,0x22,0x33 back-to-back with `m_ready`=1 → `m_data` shows 0x11,0x22,0x33 on consecutive cycles one cycle later; `count` stays 1; `s_ready` is 0 only in the first cycle after release.
- Stall fill: `m_ready`=0, offer 0xA1,0xA2,0xA3 continuously → 0xA1 and 0xA2 accepted, `count`=2, `s_ready`=0; 0xA3 held upstream; `m_data`=0xA1 stable throughout.
- Drain after stall: from FULL, raise `m_ready` → outputs 0xA1, 0xA2, then 0xA3 in order; `s_ready` returns to 1 the cycle after FULL→BUSY.
- `sclr` while FULL with `s_valid`=1 → next cycle `count`=0, `m_valid`=0, `m_data`=`RESET_VALUE`, `s_ready`=1; the offered beat is not output.
- Asynchronous reset asserted mid-stream with `count`=2 → outputs take the reset values immediately, without a clock edge.
- Random `s_valid`/`m_ready` at 50% density for 10k cycles, with a scoreboard → in-order data, no loss or duplication, and `m_data` stable whenever the output is stalled.
